// File: rtl/data_mem_ctrl.sv
// Data-memory controller: host preload in IDLE, processor access in RUN,
// then a ready/valid stream of the first DUMP_LEN words, ending in a sticky DONE.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DUMP_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [11:0] host_data,
    input  logic        start,
    output logic        proc_run,
    input  logic        dm_en,
    input  logic [11:0] ar_out,
    input  logic [16:0] bus_out,
    input  logic        end_process,
    output logic [11:0] dm_out,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [11:0] tx_addr,
    output logic [11:0] tx_data,
    output logic        dump_done
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DUMP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                proc_run_q;
    logic                tx_valid_q;
    logic                dump_done_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                we_c;
    logic [ADDR_W-1:0]   waddr_c;
    logic [DATA_W-1:0]   wdata_c;

    // Upper address bits and bus_out[16:12] are intentionally unused (address wrap).
    logic unused_c;
    assign unused_c = ^{host_addr, ar_out, bus_out};

    // Next-state, dump counter and write-port select
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                we_c    = host_we;
                waddr_c = host_addr[ADDR_W-1:0];
                wdata_c = host_data;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                we_c    = dm_en;
                waddr_c = ar_out[ADDR_W-1:0];
                wdata_c = bus_out[DATA_W-1:0];
                if (end_process) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end
            end
            DUMP: begin
                if (tx_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered state-decode outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            proc_run_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proc_run_q  <= (state_d == RUN);
            tx_valid_q  <= (state_d == DUMP);
            dump_done_q <= (state_d == DONE);
        end
    end

    // Memory array is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[waddr_c] <= wdata_c;
        end
    end

    assign dm_out    = mem_q[ar_out[ADDR_W-1:0]];
    assign tx_data   = mem_q[cnt_q];
    assign tx_addr   = DATA_W'(cnt_q);
    assign proc_run  = proc_run_q;
    assign tx_valid  = tx_valid_q;
    assign dump_done = dump_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed sequence with randomized data, checked
// against an array model of the memory and a beat counter for the dump stream.
module tb_data_mem_ctrl;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DUMP_LEN = 4;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic        clk;
    logic        rst_n;
    logic        host_we;
    logic [11:0] host_addr;
    logic [11:0] host_data;
    logic        start;
    logic        proc_run;
    logic        dm_en;
    logic [11:0] ar_out;
    logic [16:0] bus_out;
    logic        end_process;
    logic [11:0] dm_out;
    logic        tx_valid;
    logic        tx_ready;
    logic [11:0] tx_addr;
    logic [11:0] tx_data;
    logic        dump_done;

    int checks   = 0;
    int failures = 0;
    int model_mem [DEPTH];

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DUMP_LEN(DUMP_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .start(start), .proc_run(proc_run),
        .dm_en(dm_en), .ar_out(ar_out), .bus_out(bus_out),
        .end_process(end_process), .dm_out(dm_out),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_addr(tx_addr), .tx_data(tx_data), .dump_done(dump_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        host_we = 0; host_addr = 0; host_data = 0; start = 0;
        dm_en = 0; ar_out = 0; bus_out = 0; end_process = 0; tx_ready = 0;
    endtask

    task automatic read_chk(input string tag, input int addr12);
        ar_out = 12'(addr12);
        #1;
        chk(tag, 32'(dm_out), 32'(model_mem[addr12 % DEPTH]));
    endtask

    // Drive random processor/host writes that the DUT must ignore.
    task automatic noise();
        dm_en     = 1'($urandom);
        host_we   = 1'($urandom);
        ar_out    = 12'($urandom);
        bus_out   = 17'($urandom);
        host_addr = 12'($urandom);
        host_data = 12'($urandom);
        start     = 1'($urandom);
    endtask

    // Stream a full dump with random backpressure, comparing against the model.
    task automatic dump_random(input string tag);
        int beat = 0;
        int budget = 0;
        while (beat < int'(DUMP_LEN) && budget < 200) begin
            noise();
            tx_ready = 1'($urandom);
            #1;
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_addr"},  32'(tx_addr),  32'(beat));
            chk({tag, "_data"},  32'(tx_data),  32'(model_mem[beat]));
            tick();
            if (tx_ready) beat++;
            budget++;
        end
        if (beat < int'(DUMP_LEN)) chk({tag, "_budget"}, 32'(beat), 32'(DUMP_LEN));
        idle_inputs();
        #1;
        chk({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_end_done"},  32'(dump_done), 32'd1);
    endtask

    initial begin
        bit pattern [6];
        int beat;
        int a;
        int d;

        idle_inputs();
        rst_n = 0;
        #12;
        chk("rst_proc_run",  32'(proc_run),  32'd0);
        chk("rst_tx_valid",  32'(tx_valid),  32'd0);
        chk("rst_tx_addr",   32'(tx_addr),   32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        rst_n = 1;
        tick();

        // Preload every word (random upper address bits exercise the wrap).
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_we   = 1;
            host_addr = 12'(i + (int'($urandom_range(0, 15)) << ADDR_W));
            host_data = 12'($urandom);
            dm_en = 1; bus_out = 17'($urandom); ar_out = 12'($urandom);
            model_mem[i] = int'(host_data);
            tick();
        end
        host_we = 1; host_addr = 12'd3; host_data = 12'h0A5; model_mem[3] = 'h0A5;
        tick();
        idle_inputs();
        read_chk("preload_addr3", 3);
        chk("preload_proc_run", 32'(proc_run), 32'd0);
        for (int i = 0; i < 6; i++) read_chk("preload_rand", int'($urandom_range(0, 4095)));

        // Start with a simultaneous host write, which must still land.
        start = 1; host_we = 1; host_addr = 12'd7; host_data = 12'($urandom);
        model_mem[7] = int'(host_data);
        tick();
        idle_inputs();
        #1;
        chk("run_proc_run", 32'(proc_run), 32'd1);
        read_chk("start_write", 7);

        dm_en = 1; ar_out = 12'h005; bus_out = 17'h1_0123; model_mem[5] = 'h123;
        tick();
        idle_inputs();
        read_chk("run_write5", 5);
        host_we = 1; host_addr = 12'd5; host_data = 12'hFFF; start = 1;
        tick();
        idle_inputs();
        read_chk("run_host_ignored", 5);
        dm_en = 1; ar_out = 12'h105; bus_out = 17'h0_07FF; model_mem[5] = 'h7FF;
        tick();
        idle_inputs();
        read_chk("run_wrap", 5);

        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 4095));
            d = int'($urandom_range(0, 4095));
            dm_en = 1'($urandom); ar_out = 12'(a); bus_out = 17'(d + ($urandom_range(0, 31) << 12));
            host_we = 1'($urandom); host_addr = 12'($urandom); host_data = 12'($urandom);
            if (dm_en) model_mem[a % DEPTH] = d;
            tick();
            idle_inputs();
            read_chk("run_rand", a);
        end

        // End of program with a same-edge write to address 2.
        end_process = 1; dm_en = 1; ar_out = 12'd2; bus_out = 17'h0_0456; model_mem[2] = 'h456;
        tick();
        idle_inputs();
        #1;
        chk("dump_proc_run", 32'(proc_run), 32'd0);

        pattern = '{1, 0, 0, 1, 1, 1};
        beat = 0;
        for (int i = 0; i < 6; i++) begin
            noise();
            tx_ready = pattern[i];
            #1;
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_addr",  32'(tx_addr),  32'(beat));
            chk("bp_data",  32'(tx_data),  32'(model_mem[beat]));
            tick();
            if (pattern[i]) beat++;
        end
        idle_inputs();
        #1;
        chk("bp_beats",   32'(beat),      32'(DUMP_LEN));
        chk("done_valid", 32'(tx_valid),  32'd0);
        chk("done_flag",  32'(dump_done), 32'd1);

        // DONE ignores all writes and start.
        for (int i = 0; i < 5; i++) begin
            noise();
            end_process = 1'($urandom);
            tick();
            idle_inputs();
            #1;
            chk("done_sticky", 32'(dump_done), 32'd1);
            chk("done_no_run", 32'(proc_run),  32'd0);
        end
        for (int i = 0; i < 4; i++) read_chk("done_mem", int'($urandom_range(0, 4095)));

        // Reset returns to IDLE; memory persists.
        rst_n = 0;
        #1;
        chk("rst2_done",  32'(dump_done), 32'd0);
        chk("rst2_valid", 32'(tx_valid),  32'd0);
        chk("rst2_data",  32'(tx_data),   32'(model_mem[0]));
        #2;
        rst_n = 1;
        tick();
        start = 1;
        tick();
        idle_inputs();
        end_process = 1;
        tick();
        idle_inputs();
        tx_ready = 1;
        #1;
        chk("mid_beat0_addr", 32'(tx_addr), 32'd0);
        tick();
        tx_ready = 0;
        #1;
        chk("mid_beat1_addr", 32'(tx_addr), 32'd1);
        chk("mid_beat1_data", 32'(tx_data), 32'(model_mem[1]));
        rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_addr",  32'(tx_addr),  32'd0);
        chk("mid_rst_run",   32'(proc_run), 32'd0);
        #2;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tx_ready = 1;
            tick();
            #1;
            chk("mid_idle_valid", 32'(tx_valid),  32'd0);
            chk("mid_idle_done",  32'(dump_done), 32'd0);
            chk("mid_idle_run",   32'(proc_run),  32'd0);
        end
        idle_inputs();

        // New run with no writes, then a randomized-backpressure re-dump.
        start = 1;
        tick();
        idle_inputs();
        #1;
        chk("rerun_proc_run", 32'(proc_run), 32'd1);
        end_process = 1;
        tick();
        idle_inputs();
        dump_random("redump");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
